mux2_rr_arbiter: RTL and testbench

- Shares one 2:1 selected datapath (DATA_W-bit word plus last flag) between two requesters, A and B.
- Arbitrates at packet boundaries and locks the grant until the beat carrying last is accepted.
- Drives the mux select and registers the output with valid/ready handshakes on both sides.
- Sits between two producer streams and one downstream consumer.

---
 rtl/mux2_rr_arbiter_pkg.sv | 15 +
 rtl/mux2_rr_arbiter_if.sv | 39 +++
 rtl/mux2_rr_arbiter_rr_pick2.sv | 23 ++
 rtl/mux2_rr_arbiter.sv | 113 +++++++++++
 tb/tb_mux2_rr_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mux2_rr_arbiter_pkg.sv
// rtl/mux2_rr_arbiter_pkg.sv - shared types and constants for the two-source packet arbiter
package mux2_arb_pkg;

  localparam int DATA_W_DEF = 4;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// rtl/mux2_rr_arbiter_if.sv - producer A/B and consumer stream bundle for mux2_rr_arbiter
interface mux2_rr_arbiter_if #(
  parameter int DATA_W = 4
);

  logic              a_valid_in;
  logic [DATA_W-1:0] a_data_in;
  logic              a_last_in;
  logic              a_ready_out;

  logic              b_valid_in;
  logic [DATA_W-1:0] b_data_in;
  logic              b_last_in;
  logic              b_ready_out;

  logic              y_valid_out;
  logic [DATA_W-1:0] y_data_out;
  logic              y_last_out;
  logic              y_ready_in;

  modport slave (
    input  a_valid_in, a_data_in, a_last_in,
    output a_ready_out,
    input  b_valid_in, b_data_in, b_last_in,
    output b_ready_out,
    output y_valid_out, y_data_out, y_last_out,
    input  y_ready_in
  );

  modport master (
    output a_valid_in, a_data_in, a_last_in,
    input  a_ready_out,
    output b_valid_in, b_data_in, b_last_in,
    input  b_ready_out,
    input  y_valid_out, y_data_out, y_last_out,
    output y_ready_in
  );

endinterface

// File: rtl/mux2_rr_arbiter_rr_pick2.sv
// rtl/mux2_rr_arbiter_rr_pick2.sv - combinational two-request picker (round-robin or fixed A-first)
module rr_pick2
  import mux2_arb_pkg::*;
(
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic ptr_i,
  input  logic fixed_prio_i,
  output logic grant_o
);

  always_comb begin
    grant_o = SRC_A;
    if (req_a_i && !req_b_i) begin
      grant_o = SRC_A;
    end else if (!req_a_i && req_b_i) begin
      grant_o = SRC_B;
    end else if (req_a_i && req_b_i) begin
      grant_o = fixed_prio_i ? SRC_A : ptr_i;
    end
  end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// rtl/mux2_rr_arbiter.sv - packet-locked 2:1 stream arbiter with registered output
// MUX2_ARB_FIXED_PRIO_EN: when defined, A always wins simultaneous requests instead of round-robin.
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  mux2_rr_arbiter_if.slave    bus,
  output logic                sel_out,
  output logic                busy_out
);

`ifdef MUX2_ARB_FIXED_PRIO_EN
  localparam logic FIXED_PRIO = 1'b1;
`else
  localparam logic FIXED_PRIO = 1'b0;
`endif

  arb_state_t        state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              sel_q, sel_d;
  logic              y_valid_q, y_valid_d;
  logic [DATA_W-1:0] y_data_q, y_data_d;
  logic              y_last_q, y_last_d;

  logic              pick;
  logic              out_free;
  logic              a_ready, b_ready;
  logic              accept;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_last;

  rr_pick2 u_pick (
    .req_a_i      (bus.a_valid_in),
    .req_b_i      (bus.b_valid_in),
    .ptr_i        (ptr_q),
    .fixed_prio_i (FIXED_PRIO),
    .grant_o      (pick)
  );

  assign src_valid = (sel_q == SRC_B) ? bus.b_valid_in : bus.a_valid_in;
  assign src_data  = (sel_q == SRC_B) ? bus.b_data_in  : bus.a_data_in;
  assign src_last  = (sel_q == SRC_B) ? bus.b_last_in  : bus.a_last_in;
  assign out_free  = bus.y_ready_in | ~y_valid_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    y_last_d  = y_last_q;
    a_ready   = 1'b0;
    b_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.a_valid_in || bus.b_valid_in) begin
          sel_d   = pick;
          state_d = (pick == SRC_B) ? GRANT_B : GRANT_A;
        end
      end
      GRANT_A: a_ready = out_free;
      GRANT_B: b_ready = out_free;
      default: state_d = IDLE;
    endcase

    accept = (a_ready || b_ready) && src_valid;

    // Loading and draining in the same cycle keeps the register full.
    if (accept) begin
      y_valid_d = 1'b1;
      y_data_d  = src_data;
      y_last_d  = src_last;
      if (src_last) begin
        state_d = IDLE;
        ptr_d   = ~sel_q;
      end
    end else if (bus.y_ready_in) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      ptr_q     <= SRC_A;
      sel_q     <= SRC_A;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      y_last_q  <= y_last_d;
    end
  end

  assign bus.a_ready_out = a_ready;
  assign bus.b_ready_out = b_ready;
  assign bus.y_valid_out = y_valid_q;
  assign bus.y_data_out  = y_data_q;
  assign bus.y_last_out  = y_last_q;
  assign sel_out         = sel_q;
  assign busy_out        = (state_q != IDLE);

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb/tb_mux2_rr_arbiter.sv - directed and randomized checks of mux2_rr_arbiter against a beat-level model
module tb_mux2_rr_arbiter;

`ifdef MUX2_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel, busy;

  always #5 clk = ~clk;

  mux2_rr_arbiter_if #(.DATA_W(4)) bus ();

  mux2_rr_arbiter #(.DATA_W(4)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus),
    .sel_out  (sel),
    .busy_out (busy)
  );

  int tests = 0;
  int fails = 0;

  // Source queues hold {last, data}; the head is presented while the enable is set.
  logic [4:0] qa[$];
  logic [4:0] qb[$];
  logic [4:0] outlog[$];
  bit a_en, b_en, yr;
  bit av, bv;

  // Model: owner 0 = nobody, 1 = A, 2 = B; pref is the source that wins a tie.
  int         m_owner;
  bit         m_pref;
  bit         m_sel;
  bit         m_yv;
  logic [4:0] m_y;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_pref = 1'b0; m_sel = 1'b0; m_yv = 1'b0; m_y = '0;
    qa.delete(); qb.delete(); outlog.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_yv"},   {7'd0, bus.y_valid_out}, 8'd0);
    check({tag, "_yd"},   {4'd0, bus.y_data_out},  8'd0);
    check({tag, "_yl"},   {7'd0, bus.y_last_out},  8'd0);
    check({tag, "_ra"},   {7'd0, bus.a_ready_out}, 8'd0);
    check({tag, "_rb"},   {7'd0, bus.b_ready_out}, 8'd0);
    check({tag, "_sel"},  {7'd0, sel},             8'd0);
    check({tag, "_busy"}, {7'd0, busy},            8'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    a_en = 1'b0; b_en = 1'b0; yr = 1'b1;
    bus.a_valid_in = 1'b0; bus.b_valid_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_pkt(input bit to_b, input int beats);
    for (int i = 0; i < beats; i++) begin
      logic [4:0] w;
      w = {(i == beats - 1), 4'($urandom_range(0, 15))};
      if (to_b) qb.push_back(w); else qa.push_back(w);
    end
  endtask

  // One clock: drive at negedge, compare, then advance the model at posedge.
  task automatic cyc();
    bit ea, eb, acc_a, acc_b, was_idle, win_b;
    av = a_en && (qa.size() > 0);
    bv = b_en && (qb.size() > 0);
    bus.a_valid_in = av;
    bus.a_data_in  = (qa.size() > 0) ? qa[0][3:0] : 4'h0;
    bus.a_last_in  = (qa.size() > 0) ? qa[0][4]   : 1'b0;
    bus.b_valid_in = bv;
    bus.b_data_in  = (qb.size() > 0) ? qb[0][3:0] : 4'h0;
    bus.b_last_in  = (qb.size() > 0) ? qb[0][4]   : 1'b0;
    bus.y_ready_in = yr;
    #1;
    ea = (m_owner == 1) && (yr || !m_yv);
    eb = (m_owner == 2) && (yr || !m_yv);
    check("a_ready", {7'd0, bus.a_ready_out}, {7'd0, ea});
    check("b_ready", {7'd0, bus.b_ready_out}, {7'd0, eb});
    check("y_valid", {7'd0, bus.y_valid_out}, {7'd0, m_yv});
    check("y_data",  {4'd0, bus.y_data_out},  {4'd0, m_y[3:0]});
    check("y_last",  {7'd0, bus.y_last_out},  {7'd0, m_y[4]});
    check("sel",     {7'd0, sel},             {7'd0, m_sel});
    check("busy",    {7'd0, busy},            {7'd0, (m_owner != 0)});
    @(posedge clk);
    acc_a = ea && av;
    acc_b = eb && bv;
    was_idle = (m_owner == 0);
    if (m_yv && yr) begin
      outlog.push_back(m_y);
      m_yv = 1'b0;
    end
    if (acc_a) begin
      m_yv = 1'b1; m_y = qa.pop_front();
      if (m_y[4]) begin m_owner = 0; m_pref = 1'b1; end
    end
    if (acc_b) begin
      m_yv = 1'b1; m_y = qb.pop_front();
      if (m_y[4]) begin m_owner = 0; m_pref = 1'b0; end
    end
    if (was_idle && (av || bv)) begin
      win_b = bv && (!av || (!FIXED && m_pref));
      m_owner = win_b ? 2 : 1;
      m_sel = win_b;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_src;
    bus.a_valid_in = 1'b0; bus.a_data_in = '0; bus.a_last_in = 1'b0;
    bus.b_valid_in = 1'b0; bus.b_data_in = '0; bus.b_last_in = 1'b0;
    bus.y_ready_in = 1'b1;
    model_reset();
    #2;
    check_reset_outputs("rst");
    do_reset();

    // Single 3-beat A packet: data appears on cycles 2..4.
    qa.push_back(5'h01); qa.push_back(5'h02); qa.push_back(5'h13);
    a_en = 1'b1; yr = 1'b1;
    cyc(); cyc();
    check("pktA_c2_data", {4'd0, bus.y_data_out}, 8'h01);
    check("pktA_c2_valid", {7'd0, bus.y_valid_out}, 8'h01);
    cyc();
    check("pktA_c3_data", {4'd0, bus.y_data_out}, 8'h02);
    cyc();
    check("pktA_c4_data", {4'd0, bus.y_data_out}, 8'h03);
    check("pktA_c4_last", {7'd0, bus.y_last_out}, 8'h01);
    check("pktA_sel", {7'd0, sel}, 8'h00);
    for (int i = 0; i < 3; i++) cyc();
    check("pktA_idle", {7'd0, busy}, 8'h00);
    check("pktA_count", 8'(outlog.size()), 8'd3);

    // Contention between single-beat packets.
    do_reset();
    for (int i = 0; i < 4; i++) begin qa.push_back(5'h1A); qb.push_back(5'h1B); end
    a_en = 1'b1; b_en = 1'b1; yr = 1'b1;
    for (int i = 0; i < 24; i++) cyc();
    check("cont_count", 8'(outlog.size()), 8'd8);
    for (int i = 0; i < 8; i++) begin
      exp_src = FIXED ? ((i < 4) ? 4'hA : 4'hB) : ((i % 2 == 0) ? 4'hA : 4'hB);
      check($sformatf("cont_order%0d", i), {4'd0, outlog[i][3:0]}, {4'd0, exp_src});
    end

    // B drops valid mid-packet while A waits: the grant stays locked on B.
    do_reset();
    qb.push_back(5'h01); qb.push_back(5'h02); qb.push_back(5'h03); qb.push_back(5'h14);
    qa.push_back(5'h1C);
    b_en = 1'b1; yr = 1'b1;
    cyc(); cyc();
    a_en = 1'b1;
    cyc();
    b_en = 1'b0;
    cyc(); cyc();
    check("lock_sel", {7'd0, sel}, 8'h01);
    b_en = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    check("lock_count", 8'(outlog.size()), 8'd5);
    check("lock_after", {3'd0, outlog[4]}, 8'h1C);

    // Output stall: 0x5 held for three cycles, then both beats drain once.
    do_reset();
    qa.push_back(5'h05); qa.push_back(5'h16);
    a_en = 1'b1; yr = 1'b1;
    cyc(); cyc();
    yr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_data", {4'd0, bus.y_data_out}, 8'h05);
    end
    yr = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    check("stall_count", 8'(outlog.size()), 8'd2);
    check("stall_b0", {3'd0, outlog[0]}, 8'h05);
    check("stall_b1", {3'd0, outlog[1]}, 8'h16);

    // Reset asserted during beat 2 of a 4-beat A packet.
    do_reset();
    qa.push_back(5'h01); qa.push_back(5'h02); qa.push_back(5'h03); qa.push_back(5'h14);
    a_en = 1'b1; yr = 1'b1;
    cyc(); cyc();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    a_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    qb.push_back(5'h19);
    b_en = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    check("midrst_count", 8'(outlog.size()), 8'd1);
    check("midrst_b", {3'd0, outlog[0]}, 8'h19);

    // Randomized traffic checked cycle by cycle against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (qa.size() < 3 && $urandom_range(0, 3) == 0) push_pkt(1'b0, $urandom_range(1, 4));
      if (qb.size() < 3 && $urandom_range(0, 3) == 0) push_pkt(1'b1, $urandom_range(1, 4));
      a_en = ($urandom_range(0, 3) != 0);
      b_en = ($urandom_range(0, 3) != 0);
      yr   = ($urandom_range(0, 9) < 7);
      cyc();
    end
    a_en = 1'b1; b_en = 1'b1; yr = 1'b1;
    for (int i = 0; i < 200 && (qa.size() > 0 || qb.size() > 0 || m_yv); i++) cyc();
    check("rand_drained", 8'(qa.size() + qb.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
